// File: rtl/svc_axi_arbiter_rd_mo.sv
// AXI read-channel arbiter: NUM_M managers share one downstream port.
// AR is arbitrated (round-robin or fixed priority) into a one-deep register slice,
// with the manager index prepended to the ID. R is routed back combinationally by
// the ID MSBs. A per-manager counter caps bursts that have been accepted but not completed.
module svc_axi_arbiter_rd_mo #(
   parameter int NUM_M           = 2,
   parameter int AXI_ADDR_WIDTH  = 8,
   parameter int AXI_DATA_WIDTH  = 16,
   parameter int AXI_ID_WIDTH    = 4,
   parameter int M_AXI_ID_WIDTH  = AXI_ID_WIDTH + $clog2(NUM_M),
   parameter int MAX_OUTSTANDING = 4,
   parameter int ARB_MODE        = 0
) (
   input  logic                               clk,
   input  logic                               rst_n,

   input  logic [NUM_M-1:0]                   s_axi_arvalid,
   input  logic [NUM_M*AXI_ID_WIDTH-1:0]      s_axi_arid,
   input  logic [NUM_M*AXI_ADDR_WIDTH-1:0]    s_axi_araddr,
   input  logic [NUM_M*8-1:0]                 s_axi_arlen,
   input  logic [NUM_M*3-1:0]                 s_axi_arsize,
   input  logic [NUM_M*2-1:0]                 s_axi_arburst,
   output logic [NUM_M-1:0]                   s_axi_arready,

   output logic [NUM_M-1:0]                   s_axi_rvalid,
   output logic [NUM_M*AXI_ID_WIDTH-1:0]      s_axi_rid,
   output logic [NUM_M*AXI_DATA_WIDTH-1:0]    s_axi_rdata,
   output logic [NUM_M*2-1:0]                 s_axi_rresp,
   output logic [NUM_M-1:0]                   s_axi_rlast,
   input  logic [NUM_M-1:0]                   s_axi_rready,

   output logic                               m_axi_arvalid,
   output logic [M_AXI_ID_WIDTH-1:0]          m_axi_arid,
   output logic [AXI_ADDR_WIDTH-1:0]          m_axi_araddr,
   output logic [7:0]                         m_axi_arlen,
   output logic [2:0]                         m_axi_arsize,
   output logic [1:0]                         m_axi_arburst,
   input  logic                               m_axi_arready,

   input  logic                               m_axi_rvalid,
   input  logic [M_AXI_ID_WIDTH-1:0]          m_axi_rid,
   input  logic [AXI_DATA_WIDTH-1:0]          m_axi_rdata,
   input  logic [1:0]                         m_axi_rresp,
   input  logic                               m_axi_rlast,
   output logic                               m_axi_rready
);

   localparam int PW    = $clog2(NUM_M);
   localparam int CW    = $clog2(MAX_OUTSTANDING + 1);
   localparam int IDX_W = M_AXI_ID_WIDTH - AXI_ID_WIDTH;

   localparam logic [PW:0]   NUM_M_EXT = (PW+1)'(NUM_M);
   localparam logic [PW-1:0] LAST_IDX  = PW'(NUM_M - 1);
   localparam logic [CW-1:0] MAX_OUT   = CW'(MAX_OUTSTANDING);

   logic [NUM_M-1:0]          w_elig;
   logic [NUM_M-1:0]          w_gnt_oh;
   logic [NUM_M-1:0]          w_r_done;
   logic                      w_slot;
   logic                      w_found;
   logic                      w_grant;
   logic [PW-1:0]             w_gnt_idx;
   logic [PW:0]               w_cand_ext;
   logic [PW-1:0]             w_cand;
   logic [IDX_W-1:0]          w_r_idx;

   logic [AXI_ID_WIDTH-1:0]   w_sel_id;
   logic [AXI_ADDR_WIDTH-1:0] w_sel_addr;
   logic [7:0]                w_sel_len;
   logic [2:0]                w_sel_size;
   logic [1:0]                w_sel_burst;

   logic [CW-1:0]             r_out [NUM_M];
   logic [PW-1:0]             r_ptr;
   logic                      r_arvalid;
   logic [M_AXI_ID_WIDTH-1:0] r_arid;
   logic [AXI_ADDR_WIDTH-1:0] r_araddr;
   logic [7:0]                r_arlen;
   logic [2:0]                r_arsize;
   logic [1:0]                r_arburst;

   // A manager may compete only while below its outstanding-burst cap.
   always_comb begin
      w_elig = '0;
      for (int i = 0; i < NUM_M; i++) begin
         w_elig[i] = s_axi_arvalid[i] && (r_out[i] < MAX_OUT);
      end
   end

   // Pick the first eligible manager, starting at the pointer (RR) or at index 0 (fixed).
   always_comb begin
      w_found    = 1'b0;
      w_gnt_idx  = '0;
      w_cand_ext = '0;
      w_cand     = '0;
      for (int k = 0; k < NUM_M; k++) begin
         if (ARB_MODE == 1) begin
            w_cand_ext = (PW+1)'(k);
         end else begin
            w_cand_ext = {1'b0, r_ptr} + (PW+1)'(k);
            if (w_cand_ext >= NUM_M_EXT) w_cand_ext = w_cand_ext - NUM_M_EXT;
         end
         w_cand = w_cand_ext[PW-1:0];
         if (!w_found && w_elig[w_cand]) begin
            w_found   = 1'b1;
            w_gnt_idx = w_cand;
         end
      end
   end

   // The slice accepts when empty or draining this cycle; reset blocks any grant.
   assign w_slot  = !r_arvalid || m_axi_arready;
   assign w_grant = rst_n && w_slot && w_found;

   // One-hot grant and payload mux of the winning manager.
   always_comb begin
      w_gnt_oh    = '0;
      w_sel_id    = '0;
      w_sel_addr  = '0;
      w_sel_len   = '0;
      w_sel_size  = '0;
      w_sel_burst = '0;
      for (int i = 0; i < NUM_M; i++) begin
         w_gnt_oh[i] = w_grant && (w_gnt_idx == PW'(i));
         if (w_gnt_oh[i]) begin
            w_sel_id    = s_axi_arid[i*AXI_ID_WIDTH +: AXI_ID_WIDTH];
            w_sel_addr  = s_axi_araddr[i*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
            w_sel_len   = s_axi_arlen[i*8 +: 8];
            w_sel_size  = s_axi_arsize[i*3 +: 3];
            w_sel_burst = s_axi_arburst[i*2 +: 2];
         end
      end
   end

   assign s_axi_arready = w_gnt_oh;

   // AR register slice: load on grant, hold until the downstream handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_arvalid <= 1'b0;
         r_arid    <= '0;
         r_araddr  <= '0;
         r_arlen   <= '0;
         r_arsize  <= '0;
         r_arburst <= '0;
      end else if (w_grant) begin
         r_arvalid <= 1'b1;
         r_arid    <= {IDX_W'(w_gnt_idx), w_sel_id};
         r_araddr  <= w_sel_addr;
         r_arlen   <= w_sel_len;
         r_arsize  <= w_sel_size;
         r_arburst <= w_sel_burst;
      end else if (m_axi_arready) begin
         r_arvalid <= 1'b0;
      end
   end

   assign m_axi_arvalid = r_arvalid;
   assign m_axi_arid    = r_arid;
   assign m_axi_araddr  = r_araddr;
   assign m_axi_arlen   = r_arlen;
   assign m_axi_arsize  = r_arsize;
   assign m_axi_arburst = r_arburst;

   // Round-robin pointer moves just past the last winner.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= '0;
      end else if (w_grant) begin
         r_ptr <= (w_gnt_idx == LAST_IDX) ? '0 : w_gnt_idx + 1'b1;
      end
   end

   // R routing by ID MSBs; an index with no manager behind it is sunk (rready held high).
   assign w_r_idx = m_axi_rid[M_AXI_ID_WIDTH-1 -: IDX_W];

   always_comb begin
      s_axi_rvalid = '0;
      m_axi_rready = 1'b1;
      for (int i = 0; i < NUM_M; i++) begin
         if (w_r_idx == IDX_W'(i)) begin
            s_axi_rvalid[i] = m_axi_rvalid;
            m_axi_rready    = s_axi_rready[i];
         end
      end
   end

   assign s_axi_rid   = {NUM_M{m_axi_rid[AXI_ID_WIDTH-1:0]}};
   assign s_axi_rdata = {NUM_M{m_axi_rdata}};
   assign s_axi_rresp = {NUM_M{m_axi_rresp}};
   assign s_axi_rlast = {NUM_M{m_axi_rlast}};

   // Final beat of a burst delivered to manager i.
   always_comb begin
      w_r_done = '0;
      for (int i = 0; i < NUM_M; i++) begin
         w_r_done[i] = s_axi_rvalid[i] && s_axi_rready[i] && m_axi_rlast;
      end
   end

   // Outstanding counters: +1 on AR grant, -1 on last R beat, unchanged when both coincide.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_M; i++) r_out[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_M; i++) begin
            case ({w_gnt_oh[i], w_r_done[i]})
               2'b10: r_out[i] <= r_out[i] + 1'b1;
               2'b01: if (r_out[i] != '0) r_out[i] <= r_out[i] - 1'b1;
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_svc_axi_arbiter_rd_mo.sv
// Directed bench for svc_axi_arbiter_rd_mo: a round-robin instance and a
// fixed-priority instance share all inputs.
module tb_svc_axi_arbiter_rd_mo;

   logic        clk = 1'b0;
   logic        rst_n;

   logic [1:0]  arvalid;
   logic [7:0]  arid;
   logic [15:0] araddr;
   logic [15:0] arlen;
   logic [5:0]  arsize;
   logic [3:0]  arburst;
   logic [1:0]  rready;
   logic        m_arready;
   logic        m_rvalid;
   logic [4:0]  m_rid;
   logic [15:0] m_rdata;
   logic [1:0]  m_rresp;
   logic        m_rlast;

   // Round-robin instance outputs
   logic [1:0]  s_arready, s_rvalid, s_rlast;
   logic [7:0]  s_rid;
   logic [31:0] s_rdata;
   logic [3:0]  s_rresp;
   logic        m_arvalid, m_rready;
   logic [4:0]  m_arid;
   logic [7:0]  m_araddr, m_arlen;
   logic [2:0]  m_arsize;
   logic [1:0]  m_arburst;

   // Fixed-priority instance outputs
   logic [1:0]  f_arready, f_rvalid, f_rlast;
   logic [7:0]  f_rid;
   logic [31:0] f_rdata;
   logic [3:0]  f_rresp;
   logic        f_arvalid, f_rready;
   logic [4:0]  f_arid;
   logic [7:0]  f_araddr, f_arlen;
   logic [2:0]  f_arsize;
   logic [1:0]  f_arburst;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   svc_axi_arbiter_rd_mo #(.NUM_M(2), .ARB_MODE(0)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .s_axi_arvalid(arvalid), .s_axi_arid(arid), .s_axi_araddr(araddr),
      .s_axi_arlen(arlen), .s_axi_arsize(arsize), .s_axi_arburst(arburst),
      .s_axi_arready(s_arready),
      .s_axi_rvalid(s_rvalid), .s_axi_rid(s_rid), .s_axi_rdata(s_rdata),
      .s_axi_rresp(s_rresp), .s_axi_rlast(s_rlast), .s_axi_rready(rready),
      .m_axi_arvalid(m_arvalid), .m_axi_arid(m_arid), .m_axi_araddr(m_araddr),
      .m_axi_arlen(m_arlen), .m_axi_arsize(m_arsize), .m_axi_arburst(m_arburst),
      .m_axi_arready(m_arready),
      .m_axi_rvalid(m_rvalid), .m_axi_rid(m_rid), .m_axi_rdata(m_rdata),
      .m_axi_rresp(m_rresp), .m_axi_rlast(m_rlast), .m_axi_rready(m_rready)
   );

   svc_axi_arbiter_rd_mo #(.NUM_M(2), .ARB_MODE(1)) u_dut_fp (
      .clk(clk), .rst_n(rst_n),
      .s_axi_arvalid(arvalid), .s_axi_arid(arid), .s_axi_araddr(araddr),
      .s_axi_arlen(arlen), .s_axi_arsize(arsize), .s_axi_arburst(arburst),
      .s_axi_arready(f_arready),
      .s_axi_rvalid(f_rvalid), .s_axi_rid(f_rid), .s_axi_rdata(f_rdata),
      .s_axi_rresp(f_rresp), .s_axi_rlast(f_rlast), .s_axi_rready(rready),
      .m_axi_arvalid(f_arvalid), .m_axi_arid(f_arid), .m_axi_araddr(f_araddr),
      .m_axi_arlen(f_arlen), .m_axi_arsize(f_arsize), .m_axi_arburst(f_arburst),
      .m_axi_arready(m_arready),
      .m_axi_rvalid(m_rvalid), .m_axi_rid(m_rid), .m_axi_rdata(m_rdata),
      .m_axi_rresp(m_rresp), .m_axi_rlast(m_rlast), .m_axi_rready(f_rready)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_inputs();
      arvalid = '0; arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
      rready = '0; m_arready = 1'b0; m_rvalid = 1'b0; m_rid = '0; m_rdata = '0;
      m_rresp = '0; m_rlast = 1'b0;
   endtask

   // Pulse reset across one rising edge; returns just after a rising edge with rst_n high.
   task automatic reset_dut();
      @(negedge clk);
      rst_n = 1'b0;
      clear_inputs();
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      clear_inputs();

      // Reset: requests present but no grant; R path still live
      arvalid = 2'b11; arid = 8'h33; m_arready = 1'b1;
      m_rvalid = 1'b1; m_rid = 5'h15; rready = 2'b11; m_rdata = 16'hA5A5;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_m_arvalid", 32'(m_arvalid), 32'h0);
      chk("rst_s_arready", 32'(s_arready), 32'h0);
      chk("rst_fp_arready", 32'(f_arready), 32'h0);
      chk("rst_r_rvalid", 32'(s_rvalid), 32'h2);
      chk("rst_r_rready", 32'(m_rready), 32'h1);

      // Round robin: grants alternate 0,1,0,1 at one AR per clock
      m_rvalid = 1'b0; m_rid = '0; rready = 2'b00;
      araddr = {8'h20, 8'h10};
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); #1;
         chk("rr_arready", 32'(s_arready), (i % 2 == 0) ? 32'h1 : 32'h2);
         @(posedge clk); #1;
         chk("rr_m_arvalid", 32'(m_arvalid), 32'h1);
         chk("rr_m_arid", 32'(m_arid), (i % 2 == 0) ? 32'h03 : 32'h13);
         chk("rr_m_araddr", 32'(m_araddr), (i % 2 == 0) ? 32'h10 : 32'h20);
      end

      // Fixed priority: manager 0 wins until its cap of 4, then manager 1
      reset_dut();
      arvalid = 2'b11; arid = 8'h33; m_arready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); #1;
         chk("fp_arready_m0", 32'(f_arready), 32'h1);
         @(posedge clk); #1;
         chk("fp_m_arid_m0", 32'(f_arid), 32'h03);
      end
      @(negedge clk); #1;
      chk("fp_arready_m1", 32'(f_arready), 32'h2);
      @(posedge clk); #1;
      chk("fp_m_arid_m1", 32'(f_arid), 32'h13);

      // Outstanding cap on manager 0, released only by a last beat
      reset_dut();
      arvalid = 2'b01; arid = 8'h07; araddr = 16'h0040; m_arready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); #1;
         chk("cap_arready", 32'(s_arready), 32'h1);
         @(posedge clk); #1;
         chk("cap_m_arid", 32'(m_arid), 32'h07);
      end
      @(negedge clk); #1;
      chk("cap_full", 32'(s_arready), 32'h0);
      @(posedge clk);
      @(negedge clk); #1;
      chk("cap_full_hold", 32'(s_arready), 32'h0);
      m_rvalid = 1'b1; m_rid = 5'h07; m_rlast = 1'b0; rready = 2'b01;
      #1;
      chk("cap_r_rvalid", 32'(s_rvalid), 32'h1);
      chk("cap_r_rready", 32'(m_rready), 32'h1);
      @(negedge clk); #1;
      chk("cap_nonlast", 32'(s_arready), 32'h0);
      m_rlast = 1'b1;
      #1;
      chk("cap_last_same_cycle", 32'(s_arready), 32'h0);
      @(posedge clk); #1;
      m_rvalid = 1'b0; m_rlast = 1'b0;
      @(negedge clk); #1;
      chk("cap_after_rlast", 32'(s_arready), 32'h1);
      @(posedge clk); #1;
      chk("cap_regrant_arid", 32'(m_arid), 32'h07);
      arvalid = 2'b00;

      // Downstream stall: slice holds its payload, no further grants
      reset_dut();
      arvalid = 2'b10; arid = 8'hA0; araddr = 16'h5C00; arlen = 16'h0700;
      arsize = 6'b010_000; arburst = 4'b01_00; m_arready = 1'b0;
      @(negedge clk); #1;
      chk("stall_first_arready", 32'(s_arready), 32'h2);
      @(posedge clk); #1;
      chk("stall_m_arid", 32'(m_arid), 32'h1A);
      araddr = 16'h7700; arlen = 16'h0300;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         chk("stall_arready", 32'(s_arready), 32'h0);
         @(posedge clk); #1;
         chk("stall_arvalid", 32'(m_arvalid), 32'h1);
         chk("stall_arid", 32'(m_arid), 32'h1A);
         chk("stall_araddr", 32'(m_araddr), 32'h5C);
         chk("stall_arlen", 32'(m_arlen), 32'h07);
         chk("stall_arsize", 32'(m_arsize), 32'h2);
         chk("stall_arburst", 32'(m_arburst), 32'h1);
      end
      @(negedge clk);
      m_arready = 1'b1;
      #1;
      chk("stall_slot_on_hs", 32'(s_arready), 32'h2);
      @(posedge clk); #1;
      chk("stall_next_araddr", 32'(m_araddr), 32'h77);
      chk("stall_next_arlen", 32'(m_arlen), 32'h03);
      arvalid = 2'b00;
      @(posedge clk); #1;
      chk("stall_drained", 32'(m_arvalid), 32'h0);

      // Last beat and new AR for manager 1 in one cycle: count stays at 2
      @(negedge clk);
      arvalid = 2'b10; arid = 8'h10;
      m_rvalid = 1'b1; m_rid = 5'h10; m_rlast = 1'b1; rready = 2'b10;
      #1;
      chk("coin_arready", 32'(s_arready), 32'h2);
      chk("coin_rvalid", 32'(s_rvalid), 32'h2);
      chk("coin_rready", 32'(m_rready), 32'h1);
      @(posedge clk); #1;
      m_rvalid = 1'b0; m_rlast = 1'b0;
      @(negedge clk); #1;
      chk("coin_cnt2", 32'(s_arready), 32'h2);
      @(negedge clk); #1;
      chk("coin_cnt3", 32'(s_arready), 32'h2);
      @(negedge clk); #1;
      chk("coin_cnt4_full", 32'(s_arready), 32'h0);
      arvalid = 2'b00;

      // R routing and broadcast
      m_rvalid = 1'b1; m_rid = 5'h15; rready = 2'b01; m_rdata = 16'hBEEF;
      m_rresp = 2'b10; m_rlast = 1'b0;
      #1;
      chk("route_rvalid_m1", 32'(s_rvalid), 32'h2);
      chk("route_rid_m1", 32'(s_rid[7:4]), 32'h5);
      chk("route_rready_m1", 32'(m_rready), 32'h0);
      chk("route_rdata", s_rdata, 32'hBEEFBEEF);
      chk("route_rresp", 32'(s_rresp), 32'hA);
      m_rid = 5'h05;
      #1;
      chk("route_rvalid_m0", 32'(s_rvalid), 32'h1);
      chk("route_rready_m0", 32'(m_rready), 32'h1);
      m_rvalid = 1'b0;
      #1;
      chk("route_idle", 32'(s_rvalid), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/svc_axi_arbiter_rd_mo.md
SVC_AXI_ARBITER_RD_MO -- requirements
Module: svc_axi_arbiter_rd_mo

Interface
REQ-001 SHALL have parameter NUM_M, default 2: number of upstream managers, 2..16.
REQ-002 SHALL have parameter AXI_ADDR_WIDTH, default 8: address width.
REQ-003 SHALL have parameter AXI_DATA_WIDTH, default 16: data width.
REQ-004 SHALL have parameter AXI_ID_WIDTH, default 4: upstream ID width.
REQ-005 SHALL have parameter M_AXI_ID_WIDTH, default AXI_ID_WIDTH+$clog2(NUM_M): downstream ID width.
REQ-006 SHALL have parameter MAX_OUTSTANDING, default 4: per-manager limit on accepted-but-incomplete bursts, at least 1.
REQ-007 SHALL have parameter ARB_MODE, default 0: 0 is round-robin, 1 is fixed priority with the lowest index winning.
REQ-008 SHALL have clk, input, 1: the single clock.
REQ-009 SHALL have rst_n, input, 1: asynchronous active-low reset.
REQ-010 SHALL have s_axi_arvalid, input, NUM_M: per-manager AR valid.
REQ-011 SHALL have s_axi_arid, input, NUM_M x AXI_ID_WIDTH: AR ID.
REQ-012 SHALL have s_axi_araddr, arlen, arsize and arburst, all inputs, NUM_M x {AXI_ADDR_WIDTH, 8, 3, 2}: AR payload.
REQ-013 SHALL have s_axi_arready, output, NUM_M: AR ready.
REQ-014 SHALL have s_axi_rvalid, output, NUM_M: R valid.
REQ-015 SHALL have s_axi_rid, output, NUM_M x AXI_ID_WIDTH: R ID.
REQ-016 SHALL have s_axi_rdata, rresp and rlast, all outputs, NUM_M x {AXI_DATA_WIDTH, 2, 1}: R payload.
REQ-017 SHALL have s_axi_rready, input, NUM_M: R ready.
REQ-018 SHALL have m_axi_arvalid, output, 1, and m_axi_arid, output, M_AXI_ID_WIDTH.
REQ-019 SHALL have m_axi_araddr, arlen, arsize and arburst, all outputs, {AXI_ADDR_WIDTH, 8, 3, 2}.
REQ-020 SHALL have m_axi_arready, input, 1.
REQ-021 SHALL have m_axi_rvalid, input, 1, and m_axi_rid, input, M_AXI_ID_WIDTH.
REQ-022 SHALL have m_axi_rdata, rresp and rlast, all inputs, {AXI_DATA_WIDTH, 2, 1}.
REQ-023 SHALL have m_axi_rready, output, 1.

Function
REQ-024 SHALL treat manager i as eligible when s_axi_arvalid[i] is high and outstanding[i] < MAX_OUTSTANDING.
REQ-025 SHALL make an AR slot available in a cycle when m_axi_arvalid is low or (m_axi_arvalid and m_axi_arready) is true.
REQ-026 SHALL, in a cycle with an available AR slot, select at most one eligible manager g, assert s_axi_arready[g] for that cycle only, and register its payload into the m_axi_ar* outputs.
REQ-027 SHALL present m_axi_arvalid exactly 1 cycle after the s_axi handshake.
REQ-028 SHALL hold m_axi_arvalid and all m_axi_ar* fields stable until m_axi_arready is high.
REQ-029 SHALL set m_axi_arid to {g, s_axi_arid[g]}, with the index in the MSBs.
REQ-030 SHALL, when ARB_MODE=0, search from the pointer upward with wrap, and set the pointer to (g+1) mod NUM_M after each grant.
REQ-031 SHALL, when ARB_MODE=1, grant the lowest eligible index.
REQ-032 SHALL increment outstanding[i] on an s AR handshake for manager i.
REQ-033 SHALL decrement outstanding[i] on a routed R handshake with rlast for manager i.
REQ-034 SHALL leave outstanding[i] unchanged when the increment and decrement occur in the same cycle.
REQ-035 SHALL size each outstanding counter at $clog2(MAX_OUTSTANDING+1) bits, and the counter SHALL never overflow or underflow.
REQ-036 SHALL route R combinationally, with idx = m_axi_rid MSBs.
REQ-037 SHALL drive s_axi_rvalid[idx] = m_axi_rvalid and every other s_axi_rvalid bit to 0.
REQ-038 SHALL drive m_axi_rready = s_axi_rready[idx].
REQ-039 SHALL drive s_axi_rid to the m_axi_rid LSBs, and SHALL broadcast rdata, rresp and rlast to all managers.
REQ-040 SHALL handle idx >= NUM_M by driving m_axi_rready=1 and all s_axi_rvalid bits to 0, silently sinking the beat.
REQ-041 SHALL place no ordering constraint between AR and R, allowing R beats of different managers to interleave beat by beat.
REQ-042 SHALL have zero R-path latency, with no R buffering.
REQ-043 SHALL keep s_axi_arready[i] low for any manager at MAX_OUTSTANDING, even with the AR slot free.

Reset
REQ-044 SHALL, while rst_n is low, force m_axi_arvalid=0, all outstanding counters=0, the round-robin pointer=0 and s_axi_arready=0.
REQ-045 SHALL, while rst_n is low, leave the R-path outputs combinational from m_axi_r* and unaffected by reset.
REQ-046 SHALL discard pending AR state when reset is asserted mid-burst; in-flight responses arriving after reset are undefined.
REQ-047 SHALL make the first grant possible on the first clk edge after rst_n deasserts.

Verification
REQ-048 SHALL pass this scenario: NUM_M=2, ARB_MODE=0, both arvalid held, arready=1, arid=3 -> grants alternate 0,1,0,1; m_axi_arid = 0x03, 0x13, ...; one AR per clock.
REQ-049 SHALL pass this scenario: ARB_MODE=1, both requesting -> manager 0 is granted until its outstanding count reaches 4, then manager 1 is granted.
REQ-050 SHALL pass this scenario: manager 0 issues 4 ARs with no R returned -> s_axi_arready[0] stays 0; one rlast beat for manager 0 -> next cycle s_axi_arready[0] may assert again.
REQ-051 SHALL pass this scenario: m_axi_rid=0x15 with rvalid, and s_axi_rready[1]=0 -> s_axi_rvalid=2'b10, s_axi_rid[1]=5, m_axi_rready=0.
REQ-052 SHALL pass this scenario: m_axi_arready held low for 3 cycles -> m_axi_ar* stable throughout, and no further s_axi_arready is asserted.
REQ-053 SHALL pass this scenario: R rlast for manager 1 coincides with a new AR for manager 1 -> outstanding[1] is unchanged.
